// File: rtl/mem_op_queue_if.sv
// Dispatch, wakeup and issue bundle of the in-order memory-op queue.
// The master side is dispatch/writeback/memory; the slave side is the queue.
interface mem_op_queue_if #(
  parameter int REG_W      = 4,
  parameter int OP_W       = 2,
  parameter int WAKE_PORTS = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_use_ra;
  logic                        in_use_rt;
  logic                        in_use_rw;
  logic [REG_W-1:0]            in_ra_addr;
  logic [REG_W-1:0]            in_rt_addr;
  logic [REG_W-1:0]            in_rw_addr;
  logic                        in_ra_ready;
  logic                        in_rt_ready;
  logic [OP_W-1:0]             in_mem_op;
  logic [WAKE_PORTS-1:0]       wake_valid;
  logic [WAKE_PORTS*REG_W-1:0] wake_addr;
  logic                        issue_valid;
  logic                        issue_ready;
  logic                        issue_use_ra;
  logic                        issue_use_rt;
  logic                        issue_use_rw;
  logic [REG_W-1:0]            issue_ra_addr;
  logic [REG_W-1:0]            issue_rt_addr;
  logic [REG_W-1:0]            issue_rw_addr;
  logic [OP_W-1:0]             issue_mem_op;

  modport master (
    output in_valid, in_use_ra, in_use_rt, in_use_rw,
    output in_ra_addr, in_rt_addr, in_rw_addr,
    output in_ra_ready, in_rt_ready, in_mem_op,
    output wake_valid, wake_addr, issue_ready,
    input  in_ready, issue_valid,
    input  issue_use_ra, issue_use_rt, issue_use_rw,
    input  issue_ra_addr, issue_rt_addr, issue_rw_addr,
    input  issue_mem_op
  );

  modport slave (
    input  in_valid, in_use_ra, in_use_rt, in_use_rw,
    input  in_ra_addr, in_rt_addr, in_rw_addr,
    input  in_ra_ready, in_rt_ready, in_mem_op,
    input  wake_valid, wake_addr, issue_ready,
    output in_ready, issue_valid,
    output issue_use_ra, issue_use_rt, issue_use_rw,
    output issue_ra_addr, issue_rt_addr, issue_rw_addr,
    output issue_mem_op
  );
endinterface

// File: rtl/mem_op_queue.sv
// In-order load/store queue with source wakeup tracking.
// Only the head may issue, so memory ordering follows dispatch order.
module mem_op_queue #(
  parameter int DEPTH      = 8,
  parameter int NUM_REG    = 16,
  parameter int WAKE_PORTS = 2,
  parameter int OP_W       = 2,
  localparam int REG_W = $clog2(NUM_REG),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  mem_op_queue_if.slave    q,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic             valid;
    logic             use_ra;
    logic             use_rt;
    logic             use_rw;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rw;
    logic [OP_W-1:0]  mem_op;
    logic             ra_rdy;
    logic             rt_rdy;
  } entry_t;

  entry_t           ents [DEPTH];
  entry_t           new_ent;
  entry_t           head_ent;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             enq;
  logic             deq;

  function automatic logic hit(
    input logic [WAKE_PORTS-1:0]       v,
    input logic [WAKE_PORTS*REG_W-1:0] a,
    input logic [REG_W-1:0]            t
  );
    logic r;
    r = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++) begin
      if (v[k] && a[k*REG_W +: REG_W] == t) r = 1'b1;
    end
    return r;
  endfunction

  assign head_ent = ents[head];

  assign q.in_ready    = (count != CNT_W'(DEPTH));
  assign q.issue_valid = head_ent.valid && head_ent.ra_rdy
                         && head_ent.rt_rdy;

  // Free slots are kept all-zero, so an empty queue presents zero fields.
  assign q.issue_use_ra  = head_ent.use_ra;
  assign q.issue_use_rt  = head_ent.use_rt;
  assign q.issue_use_rw  = head_ent.use_rw;
  assign q.issue_ra_addr = head_ent.ra;
  assign q.issue_rt_addr = head_ent.rt;
  assign q.issue_rw_addr = head_ent.rw;
  assign q.issue_mem_op  = head_ent.mem_op;

  assign enq = q.in_valid && q.in_ready;
  assign deq = q.issue_valid && q.issue_ready;

  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.use_ra = q.in_use_ra;
    new_ent.use_rt = q.in_use_rt;
    new_ent.use_rw = q.in_use_rw;
    new_ent.ra     = q.in_ra_addr;
    new_ent.rt     = q.in_rt_addr;
    new_ent.rw     = q.in_rw_addr;
    new_ent.mem_op = q.in_mem_op;
    new_ent.ra_rdy = !q.in_use_ra || q.in_ra_ready
                     || hit(q.wake_valid, q.wake_addr, q.in_ra_addr);
    new_ent.rt_rdy = !q.in_use_rt || q.in_rt_ready
                     || hit(q.wake_valid, q.wake_addr, q.in_rt_addr);
  end

  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ents[i].valid && ents[i].use_ra
            && hit(q.wake_valid, q.wake_addr, ents[i].ra))
          ents[i].ra_rdy <= 1'b1;
        if (ents[i].valid && ents[i].use_rt
            && hit(q.wake_valid, q.wake_addr, ents[i].rt))
          ents[i].rt_rdy <= 1'b1;
      end
      // Later writes win: retiring head drops any same-cycle wakeup.
      if (deq) begin
        ents[head] <= '0;
        head       <= head + PTR_W'(1);
      end
      if (enq) begin
        ents[tail] <= new_ent;
        tail       <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

endmodule
